dcache_refill_ctrl: RTL and testbench

Lookup and miss/refill controller for the 2-way, 32-set data cache. It drives the set index into the valid-bit and tag arrays and reads back their outputs. It detects hit or miss and picks a victim way. On a miss it fetches a 4-word line from memory, then commits the line with a single valid_write/tag_we pulse naming the refilled way. It is the writing initiator of the valid array's (index, way_sel, valid_write) interface.

---
 rtl/dcache_refill_ctrl_if.sv | 26 ++
 rtl/dcache_refill_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_ctrl_if.sv
// Line-refill read channel between the data-cache refill controller (master) and memory (slave).
interface dcache_refill_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_rreq;
   logic [ADDR_W-1:0] mem_raddr;
   logic              mem_rrdy;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_rreq,
      output mem_raddr,
      input  mem_rrdy,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_rreq,
      input  mem_raddr,
      output mem_rrdy,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Lookup and miss/refill controller for the 2-way, 32-set data cache: hit detection,
// victim choice with per-set LRU, 4-beat line fetch and a single-cycle valid/tag commit.
module dcache_refill_ctrl #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned INDEX_W  = 5,
   parameter int unsigned OFFSET_W = 4,
   parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
   parameter int unsigned BEATS    = 4,
   localparam int unsigned CNT_W   = $clog2(BEATS)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                req_valid,
   input  logic [ADDR_W-1:0]   req_addr,
   output logic                stall,
   output logic                hit,
   output logic                hit_way,
   output logic [INDEX_W-1:0]  index,
   input  logic [1:0]          valid,
   input  logic [TAG_W-1:0]    tag0,
   input  logic [TAG_W-1:0]    tag1,
   output logic                valid_write,
   output logic                tag_we,
   output logic                way_sel,
   dcache_refill_ctrl_if.master mem,
   output logic                refill_we,
   output logic [CNT_W-1:0]    refill_word,
   output logic [31:0]         refill_data
);

   typedef enum logic [1:0] {StIdle, StReq, StFill, StCommit} state_e;

   state_e                    state_q;
   logic [TAG_W-1:0]          tag_q;
   logic [INDEX_W-1:0]        idx_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [(1<<INDEX_W)-1:0]   lru_q;
   logic                      rreq_q;
   logic                      commit_q;
   logic                      way_q;

   logic [INDEX_W-1:0]        req_idx;
   logic [TAG_W-1:0]          req_tag;
   logic                      hit0;
   logic                      hit1;
   logic                      idle;
   logic                      fill;
   logic                      victim;
   logic                      unused_offset;

   assign req_idx       = req_addr[OFFSET_W +: INDEX_W];
   assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
   assign unused_offset = ^req_addr[OFFSET_W-1:0];

   assign idle = (state_q == StIdle);
   assign fill = (state_q == StFill);
   assign hit0 = req_valid & valid[0] & (tag0 == req_tag);
   assign hit1 = req_valid & valid[1] & (tag1 == req_tag);

   // Fill an empty way first; only fall back to LRU once both ways hold lines.
   assign victim = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_q[req_idx]);

   // Lookup outputs are combinational, so they are forced low while reset is held.
   assign hit     = rstn & idle & (hit0 | hit1);
   assign hit_way = rstn & idle & hit1;
   assign stall   = rstn & (!idle | (req_valid & !(hit0 | hit1)));
   assign index   = idle ? req_idx : idx_q;

   assign valid_write    = commit_q;
   assign tag_we         = commit_q;
   assign way_sel        = way_q;
   assign mem.mem_rreq   = rreq_q;
   assign mem.mem_raddr  = rreq_q ? {tag_q, idx_q, {OFFSET_W{1'b0}}} : '0;
   assign refill_we      = fill & mem.mem_rvalid;
   assign refill_word    = fill ? cnt_q : '0;
   assign refill_data    = rstn ? mem.mem_rdata : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         tag_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         lru_q    <= '0;
         rreq_q   <= 1'b0;
         commit_q <= 1'b0;
         way_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  if (hit0 || hit1) begin
                     lru_q[req_idx] <= ~hit1;
                  end else begin
                     tag_q   <= req_tag;
                     idx_q   <= req_idx;
                     way_q   <= victim;
                     rreq_q  <= 1'b1;
                     state_q <= StReq;
                  end
               end
            end
            StReq: begin
               if (mem.mem_rrdy) begin
                  rreq_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StFill;
               end
            end
            StFill: begin
               if (mem.mem_rvalid) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(BEATS - 1)) begin
                     commit_q <= 1'b1;
                     state_q  <= StCommit;
                  end
               end
            end
            StCommit: begin
               lru_q[idx_q] <= ~way_q;
               commit_q     <= 1'b0;
               way_q        <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: models the valid/tag arrays and a transaction-level
// view of the cache, compares every output on each falling edge, plus directed literal checks.
module tb_dcache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        stall, hit, hit_way, valid_write, tag_we, way_sel, refill_we;
   logic [4:0]  index;
   logic [1:0]  valid;
   logic [22:0] tag0, tag1;
   logic [1:0]  refill_word;
   logic [31:0] refill_data;

   dcache_refill_ctrl_if mif ();

   dcache_refill_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .stall       (stall),
      .hit         (hit),
      .hit_way     (hit_way),
      .index       (index),
      .valid       (valid),
      .tag0        (tag0),
      .tag1        (tag1),
      .valid_write (valid_write),
      .tag_we      (tag_we),
      .way_sel     (way_sel),
      .mem         (mif),
      .refill_we   (refill_we),
      .refill_word (refill_word),
      .refill_data (refill_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int n_vw   = 0;
   int n_we   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
   endtask

   // Valid/tag arrays, written by the DUT's commit pulse.
   logic [1:0]  arr_valid [32];
   logic [22:0] arr_tag0  [32];
   logic [22:0] arr_tag1  [32];

   assign valid = arr_valid[index];
   assign tag0  = arr_tag0[index];
   assign tag1  = arr_tag1[index];

   // Transaction-level model of the cache.
   bit          m_lru [32];
   bit          m_busy, m_granted, m_victim;
   int          m_beats;
   logic [22:0] m_tag;
   logic [4:0]  m_idx;

   always @(posedge clk) begin
      if (rstn) begin
         if (valid_write) arr_valid[index][way_sel] <= 1'b1;
         if (tag_we) begin
            if (way_sel) arr_tag1[index] <= m_tag;
            else arr_tag0[index] <= m_tag;
         end
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         foreach (m_lru[i]) m_lru[i] = 1'b0;
         m_busy = 0; m_granted = 0; m_victim = 0; m_beats = 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            logic [4:0]  ri;
            logic [22:0] rt;
            bit h0, h1;
            ri = req_addr[8:4];
            rt = req_addr[31:9];
            h0 = arr_valid[ri][0] && arr_tag0[ri] == rt;
            h1 = arr_valid[ri][1] && arr_tag1[ri] == rt;
            if (h0 || h1) m_lru[ri] = !h1;
            else begin
               m_busy = 1; m_granted = 0; m_beats = 0;
               m_idx = ri; m_tag = rt;
               m_victim = !arr_valid[ri][0] ? 1'b0 : (!arr_valid[ri][1] ? 1'b1 : m_lru[ri]);
            end
         end
      end else if (!m_granted) begin
         if (mif.mem_rrdy) m_granted = 1;
      end else if (m_beats < 4) begin
         if (mif.mem_rvalid) m_beats++;
      end else begin
         m_lru[m_idx] = !m_victim;
         m_busy = 0;
      end
   end

   logic        e_stall, e_hit, e_hway, e_vw, e_way, e_rreq, e_rwe;
   logic [4:0]  e_idx;
   logic [1:0]  e_word;
   logic [31:0] e_raddr, e_rdata;

   always @(negedge clk) begin
      if (chk_on) begin
         {e_stall, e_hit, e_hway, e_vw, e_way, e_rreq, e_rwe} = '0;
         e_word = '0; e_raddr = '0; e_rdata = '0;
         e_idx = req_addr[8:4];
         if (rstn) begin
            e_rdata = mif.mem_rdata;
            if (!m_busy) begin
               bit h0, h1;
               h0 = req_valid && arr_valid[e_idx][0] && arr_tag0[e_idx] == req_addr[31:9];
               h1 = req_valid && arr_valid[e_idx][1] && arr_tag1[e_idx] == req_addr[31:9];
               e_hit = h0 | h1; e_hway = h1; e_stall = req_valid & !(h0 | h1);
            end else begin
               e_idx = m_idx; e_stall = 1; e_way = m_victim;
               if (!m_granted) begin
                  e_rreq = 1; e_raddr = {m_tag, m_idx, 4'b0};
               end else if (m_beats < 4) begin
                  e_rwe = mif.mem_rvalid; e_word = 2'(m_beats);
               end else e_vw = 1;
            end
         end
         chk("stall", stall, e_stall);
         chk("hit", hit, e_hit);
         chk("hit_way", hit_way, e_hway);
         chk("index", index, e_idx);
         chk("valid_write", valid_write, e_vw);
         chk("tag_we", tag_we, e_vw);
         chk("way_sel", way_sel, e_way);
         chk("mem_rreq", mif.mem_rreq, e_rreq);
         chk("mem_raddr", mif.mem_raddr, e_raddr);
         chk("refill_we", refill_we, e_rwe);
         chk("refill_word", refill_word, e_word);
         chk("refill_data", refill_data, e_rdata);
         if (valid_write === 1'b1) n_vw++;
         if (refill_we === 1'b1) n_we++;
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Starts in REQ; returns one step into COMMIT.
   task automatic refill(input int dly, input int gap);
      for (int i = 0; i < dly; i++) begin
         mif.mem_rvalid = (i == 0);
         cyc();
      end
      mif.mem_rvalid = 1'b0;
      mif.mem_rrdy = 1'b1;
      cyc();
      mif.mem_rrdy = 1'b0;
      for (int b = 0; b < 4; b++) begin
         cyc(gap);
         mif.mem_rvalid = 1'b1;
         mif.mem_rdata  = req_addr ^ (32'hA5A5_0000 + b);
         cyc();
         mif.mem_rvalid = 1'b0;
      end
   endtask

   int vw0, we0;

   initial begin
      mif.mem_rrdy = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h1234_5678;
      for (int i = 0; i < 32; i++) begin
         arr_valid[i] = 2'b00; arr_tag0[i] = '0; arr_tag1[i] = '0;
      end
      #1 chk_on = 1'b1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_rreq", mif.mem_rreq, 1'b0);
      chk("rst_rdata", refill_data, 32'h0);
      #11 rstn = 1'b1;
      cyc();

      // 1: cold miss on set 0x12, fills way0
      req_addr = 32'h0000_0120; req_valid = 1'b1;
      #1 chk("t1_hit", hit, 1'b0);
      chk("t1_stall", stall, 1'b1);
      cyc();
      chk("t1_rreq", mif.mem_rreq, 1'b1);
      chk("t1_raddr", mif.mem_raddr, 32'h0000_0120);
      refill(0, 0);
      chk("t1_vw", valid_write, 1'b1);
      chk("t1_way", way_sel, 1'b0);
      chk("t1_idx", index, 5'h12);
      cyc();
      chk("t1_replay", hit, 1'b1);

      // 2: fill both ways of set 3, then hit way0
      req_addr = 32'h0000_0030;
      cyc(); refill(0, 0); cyc();
      req_addr = 32'h0000_1030;
      cyc();
      chk("t2_way1", way_sel, 1'b1);
      refill(0, 0); cyc();
      chk("t2_replay_way", hit_way, 1'b1);
      cyc();
      req_addr = 32'h0000_0030;
      #1 chk("t2_hit", hit, 1'b1);
      chk("t2_hway", hit_way, 1'b0);
      chk("t2_stall", stall, 1'b0);
      cyc();

      // 3: LRU victim selection on a full set
      req_addr = 32'h0000_2030;
      cyc();
      chk("t3_way_lru1", way_sel, 1'b1);
      refill(0, 0); cyc();
      req_addr = 32'h0000_3030;
      cyc();
      chk("t3_way_lru0", way_sel, 1'b0);
      refill(0, 0); cyc();
      chk("t3_replay_way", hit_way, 1'b0);

      // 4: slow grant and gapped beats
      req_addr = 32'h0000_4050;
      cyc();
      vw0 = n_vw; we0 = n_we;
      refill(5, 2);
      cyc();
      chk("t4_vw_count", 32'(n_vw - vw0), 32'd1);
      chk("t4_we_count", 32'(n_we - we0), 32'd4);

      // 5: async reset after two beats
      req_addr = 32'h0000_5060;
      vw0 = n_vw;
      cyc();
      mif.mem_rrdy = 1'b1; cyc(); mif.mem_rrdy = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mif.mem_rvalid = 1'b1; cyc(); mif.mem_rvalid = 1'b0;
      end
      #2 rstn = 1'b0;
      #1 chk("t5_stall", stall, 1'b0);
      chk("t5_way", way_sel, 1'b0);
      chk("t5_idx", index, 5'h06);
      chk("t5_vw_none", 32'(n_vw - vw0), 32'd0);
      chk("t5_invalid", arr_valid[6], 2'b00);
      @(posedge clk);
      #3 rstn = 1'b1;
      cyc();
      chk("t5_restart", mif.mem_rreq, 1'b1);
      refill(0, 1); cyc();
      chk("t5_replay", hit, 1'b1);

      // 6: request dropped mid-fill still commits
      req_addr = 32'h0000_6070;
      cyc();
      mif.mem_rrdy = 1'b1; cyc(); mif.mem_rrdy = 1'b0;
      mif.mem_rvalid = 1'b1; cyc(); mif.mem_rvalid = 1'b0;
      req_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mif.mem_rvalid = 1'b1; cyc(); mif.mem_rvalid = 1'b0;
      end
      chk("t6_vw", valid_write, 1'b1);
      cyc();
      chk("t6_stall", stall, 1'b0);
      chk("t6_valid", arr_valid[7], 2'b01);
      cyc(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
